// File: rtl/writeback_regfile_if.sv
// Commit-stage bus: execute completion bundle, fetch handshake, operand read ports
// and architectural status. Master is the execute/fetch side, slave is the regfile.
interface writeback_regfile_if #(
  parameter int unsigned CNT_W = 32
);
  logic             exec_done;
  logic [2:0]       wselector;
  logic [31:0]      wdata;
  logic [4:0]       wrd;
  logic [31:0]      pc_target;
  logic             stall_enable;
  logic [4:0]       rs_no;
  logic [4:0]       rt_no;
  logic             fmode;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      pc;
  logic             fetch_enable;
  logic             fetch_done;
  logic [CNT_W-1:0] instret;
  logic             proto_err;

  modport master (
    output exec_done, wselector, wdata, wrd, pc_target, stall_enable,
    output rs_no, rt_no, fmode, fetch_done,
    input  rs_data, rt_data, pc, fetch_enable, instret, proto_err
  );

  modport slave (
    input  exec_done, wselector, wdata, wrd, pc_target, stall_enable,
    input  rs_no, rt_no, fmode, fetch_done,
    output rs_data, rt_data, pc, fetch_enable, instret, proto_err
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback/commit stage: int and float register banks, architectural PC,
// retired-instruction counter and the fetch/execute sequencing FSM.
module writeback_regfile #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rstn,
  writeback_regfile_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  typedef enum logic [1:0] {BOOT, FETCH, WAIT_F, WAIT_X} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fetch_enable_q, fetch_enable_d;
  logic             proto_err_q, proto_err_d;
  logic             commit_c;
  logic             wr_en_c;
  logic [XLEN-1:0]  rs_c, rt_c;
  logic [XLEN-1:0]  int_q [NREG];
  logic [XLEN-1:0]  fp_q  [NREG];

  // Sequencing, commit decision and protocol checking
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    proto_err_d = proto_err_q;
    commit_c    = 1'b0;
    wr_en_c     = 1'b0;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = WAIT_F;
      WAIT_F:  if (bus.fetch_done) state_d = WAIT_X;
      WAIT_X:  if (bus.exec_done) begin
                 state_d  = FETCH;
                 commit_c = 1'b1;
               end
      default: state_d = BOOT;
    endcase
    if (bus.exec_done && (state_q != WAIT_X)) proto_err_d = 1'b1;
    if (bus.fetch_done && (state_q != WAIT_F)) proto_err_d = 1'b1;
    if (commit_c) begin
      if (bus.stall_enable) begin
        pc_d = bus.pc_target;
      end else begin
        wr_en_c   = bus.wselector[1] && (bus.wrd != 5'd0);
        pc_d      = bus.wselector[2] ? bus.pc_target : pc_q + XLEN'(4);
        instret_d = instret_q + CNT_W'(1);
      end
    end
    fetch_enable_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      instret_q      <= '0;
      fetch_enable_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instret_q      <= instret_d;
      fetch_enable_q <= fetch_enable_d;
      proto_err_q    <= proto_err_d;
    end
  end

  // Register 0 is never written, so its storage stays zero in both banks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        int_q[i] <= '0;
        fp_q[i]  <= '0;
      end
    end else if (wr_en_c) begin
      if (bus.wselector[0]) fp_q[bus.wrd]  <= bus.wdata;
      else                  int_q[bus.wrd] <= bus.wdata;
    end
  end

  // Operand ports with write-through bypass of the committing result
  always_comb begin
    rs_c = '0;
    rt_c = '0;
    if (bus.rs_no != 5'd0) begin
      if (wr_en_c && (bus.wselector[0] == bus.fmode) && (bus.wrd == bus.rs_no))
        rs_c = bus.wdata;
      else
        rs_c = bus.fmode ? fp_q[bus.rs_no] : int_q[bus.rs_no];
    end
    if (bus.rt_no != 5'd0) begin
      if (wr_en_c && (bus.wselector[0] == bus.fmode) && (bus.wrd == bus.rt_no))
        rt_c = bus.wdata;
      else
        rt_c = bus.fmode ? fp_q[bus.rt_no] : int_q[bus.rt_no];
    end
  end

  assign bus.rs_data      = rs_c;
  assign bus.rt_data      = rt_c;
  assign bus.pc           = pc_q;
  assign bus.fetch_enable = fetch_enable_q;
  assign bus.instret      = instret_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, commits to both banks, JAL,
// flush, PC wrap, protocol errors and mid-operation reset.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  writeback_regfile_if #(.CNT_W(32)) bus ();

  writeback_regfile #(.RESET_PC(32'h100), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: step to WAIT_F, then pulse fetch_done into WAIT_X
  task automatic to_wait_x();
    tick();
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
  endtask

  task automatic set_exec(input logic [2:0] ws, input logic [4:0] rd,
                          input logic [31:0] d, input logic [31:0] tgt, input logic st);
    bus.wselector    = ws;
    bus.wrd          = rd;
    bus.wdata        = d;
    bus.pc_target    = tgt;
    bus.stall_enable = st;
    bus.exec_done    = 1'b1;
  endtask

  task automatic end_exec();
    bus.exec_done    = 1'b0;
    bus.stall_enable = 1'b0;
    bus.wselector    = 3'b000;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h100); end
    n_checks++; if (bus.fetch_enable !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", bus.fetch_enable); end
    n_checks++; if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", bus.instret); end
    n_checks++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %b want 0", bus.proto_err); end
    for (int a = 0; a < 32; a++) begin
      for (int m = 0; m < 2; m++) begin
        bus.rs_no = 5'(a);
        bus.rt_no = 5'(31 - a);
        bus.fmode = 1'(m);
        #1;
        n_checks++;
        if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_regs a=%0d m=%0d: got rs=%h rt=%h want 0", a, m, bus.rs_data, bus.rt_data);
        end
      end
    end
    rstn = 1'b1;
    #1;
    n_checks++; if (bus.fetch_enable !== 1'b0) begin n_fail++; $display("FAIL boot_fe: got %b want 0", bus.fetch_enable); end
    tick();
    n_checks++; if (bus.fetch_enable !== 1'b1) begin n_fail++; $display("FAIL first_fetch_fe: got %b want 1", bus.fetch_enable); end
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL first_fetch_pc: got %h want %h", bus.pc, 32'h100); end
  endtask

  task automatic test_write_int();
    to_wait_x();
    n_checks++; if (bus.fetch_enable !== 1'b0) begin n_fail++; $display("FAIL wait_x_fe: got %b want 0", bus.fetch_enable); end
    set_exec(3'b010, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
    bus.rs_no = 5'd5; bus.rt_no = 5'd5; bus.fmode = 1'b0;
    #1;
    n_checks++; if (bus.rs_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_rs: got %h want %h", bus.rs_data, 32'hDEADBEEF); end
    n_checks++; if (bus.rt_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_rt: got %h want %h", bus.rt_data, 32'hDEADBEEF); end
    bus.fmode = 1'b1;
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL bypass_wrong_bank: got %h want 0", bus.rs_data); end
    bus.fmode = 1'b0;
    tick();
    end_exec();
    #1;
    n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL int_pc: got %h want %h", bus.pc, 32'h104); end
    n_checks++; if (bus.instret !== 32'd1) begin n_fail++; $display("FAIL int_instret: got %0d want 1", bus.instret); end
    n_checks++; if (bus.fetch_enable !== 1'b1) begin n_fail++; $display("FAIL int_next_fe: got %b want 1", bus.fetch_enable); end
    n_checks++; if (bus.rs_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL int_r5_stored: got %h want %h", bus.rs_data, 32'hDEADBEEF); end
  endtask

  task automatic test_float();
    to_wait_x();
    set_exec(3'b011, 5'd0, 32'h3F800000, 32'h0, 1'b0);
    bus.rs_no = 5'd0; bus.fmode = 1'b1;
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL f0_bypass: got %h want 0", bus.rs_data); end
    tick();
    end_exec();
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL f0_stored: got %h want 0", bus.rs_data); end
    n_checks++; if (bus.pc !== 32'h108) begin n_fail++; $display("FAIL f0_pc: got %h want %h", bus.pc, 32'h108); end
    n_checks++; if (bus.instret !== 32'd2) begin n_fail++; $display("FAIL f0_instret: got %0d want 2", bus.instret); end
    to_wait_x();
    set_exec(3'b011, 5'd3, 32'h40490FDB, 32'h0, 1'b0);
    tick();
    end_exec();
    bus.rs_no = 5'd3; bus.fmode = 1'b1;
    #1;
    n_checks++; if (bus.rs_data !== 32'h40490FDB) begin n_fail++; $display("FAIL f3_stored: got %h want %h", bus.rs_data, 32'h40490FDB); end
    bus.fmode = 1'b0;
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL r3_untouched: got %h want 0", bus.rs_data); end
    n_checks++; if (bus.pc !== 32'h10C) begin n_fail++; $display("FAIL f3_pc: got %h want %h", bus.pc, 32'h10C); end
  endtask

  task automatic test_jal();
    to_wait_x();
    set_exec(3'b110, 5'd31, 32'h108, 32'h400, 1'b0);
    tick();
    end_exec();
    bus.rt_no = 5'd31; bus.fmode = 1'b0;
    #1;
    n_checks++; if (bus.rt_data !== 32'h108) begin n_fail++; $display("FAIL jal_r31: got %h want %h", bus.rt_data, 32'h108); end
    n_checks++; if (bus.pc !== 32'h400) begin n_fail++; $display("FAIL jal_pc: got %h want %h", bus.pc, 32'h400); end
    n_checks++; if (bus.instret !== 32'd4) begin n_fail++; $display("FAIL jal_instret: got %0d want 4", bus.instret); end
  endtask

  task automatic test_flush();
    to_wait_x();
    set_exec(3'b010, 5'd7, 32'h55, 32'h200, 1'b1);
    bus.rs_no = 5'd7; bus.fmode = 1'b0;
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL flush_bypass: got %h want 0", bus.rs_data); end
    tick();
    end_exec();
    #1;
    n_checks++; if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL flush_no_write: got %h want 0", bus.rs_data); end
    n_checks++; if (bus.instret !== 32'd4) begin n_fail++; $display("FAIL flush_instret: got %0d want 4", bus.instret); end
    n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL flush_pc: got %h want %h", bus.pc, 32'h200); end
    n_checks++; if (bus.fetch_enable !== 1'b1) begin n_fail++; $display("FAIL flush_fe: got %b want 1", bus.fetch_enable); end
  endtask

  task automatic test_proto();
    tick();
    set_exec(3'b010, 5'd5, 32'h1111, 32'h0, 1'b0);
    bus.rs_no = 5'd5; bus.fmode = 1'b0;
    tick();
    end_exec();
    #1;
    n_checks++; if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_exec_in_wait_f: got %b want 1", bus.proto_err); end
    n_checks++; if (bus.rs_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL proto_r5_kept: got %h want %h", bus.rs_data, 32'hDEADBEEF); end
    n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL proto_pc: got %h want %h", bus.pc, 32'h200); end
    n_checks++; if (bus.instret !== 32'd4) begin n_fail++; $display("FAIL proto_instret: got %0d want 4", bus.instret); end
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
    set_exec(3'b000, 5'd0, 32'h0, 32'h0, 1'b0);
    bus.fetch_done = 1'b1;
    tick();
    end_exec();
    bus.fetch_done = 1'b0;
    #1;
    n_checks++; if (bus.pc !== 32'h204) begin n_fail++; $display("FAIL both_pulses_pc: got %h want %h", bus.pc, 32'h204); end
    n_checks++; if (bus.instret !== 32'd5) begin n_fail++; $display("FAIL both_pulses_instret: got %0d want 5", bus.instret); end
    n_checks++; if (bus.fetch_enable !== 1'b1) begin n_fail++; $display("FAIL both_pulses_fe: got %b want 1", bus.fetch_enable); end
  endtask

  task automatic test_pc_wrap();
    to_wait_x();
    set_exec(3'b100, 5'd0, 32'h0, 32'hFFFFFFFC, 1'b0);
    tick();
    end_exec();
    n_checks++; if (bus.pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_redirect_pc: got %h want %h", bus.pc, 32'hFFFFFFFC); end
    to_wait_x();
    set_exec(3'b000, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    end_exec();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
    n_checks++; if (bus.instret !== 32'd7) begin n_fail++; $display("FAIL wrap_instret: got %0d want 7", bus.instret); end
  endtask

  task automatic test_reset_midop();
    to_wait_x();
    set_exec(3'b010, 5'd9, 32'h99, 32'h0, 1'b0);
    bus.rs_no = 5'd5; bus.rt_no = 5'd9; bus.fmode = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL midrst_pc: got %h want %h", bus.pc, 32'h100); end
    n_checks++; if (bus.fetch_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_fe: got %b want 0", bus.fetch_enable); end
    n_checks++; if (bus.instret !== 32'd0) begin n_fail++; $display("FAIL midrst_instret: got %0d want 0", bus.instret); end
    n_checks++; if (bus.proto_err !== 1'b0) begin n_fail++; $display("FAIL midrst_proto: got %b want 0", bus.proto_err); end
    n_checks++; if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin n_fail++; $display("FAIL midrst_regs: got rs=%h rt=%h want 0", bus.rs_data, bus.rt_data); end
    tick();
    end_exec();
    rstn = 1'b1;
    bus.fetch_done = 1'b1;
    tick();
    bus.fetch_done = 1'b0;
    #1;
    n_checks++; if (bus.proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_fetch_in_boot: got %b want 1", bus.proto_err); end
    n_checks++; if (bus.fetch_enable !== 1'b1) begin n_fail++; $display("FAIL restart_fe: got %b want 1", bus.fetch_enable); end
    n_checks++; if (bus.rt_data !== 32'd0) begin n_fail++; $display("FAIL midrst_r9_not_written: got %h want 0", bus.rt_data); end
    to_wait_x();
    set_exec(3'b000, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    end_exec();
    n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL restart_pc: got %h want %h", bus.pc, 32'h104); end
    n_checks++; if (bus.instret !== 32'd1) begin n_fail++; $display("FAIL restart_instret: got %0d want 1", bus.instret); end
  endtask

  initial begin
    rstn             = 1'b0;
    bus.exec_done    = 1'b0;
    bus.wselector    = 3'b000;
    bus.wdata        = 32'h0;
    bus.wrd          = 5'd0;
    bus.pc_target    = 32'h0;
    bus.stall_enable = 1'b0;
    bus.rs_no        = 5'd0;
    bus.rt_no        = 5'd0;
    bus.fmode        = 1'b0;
    bus.fetch_done   = 1'b0;
    test_reset();
    test_write_int();
    test_float();
    test_jal();
    test_flush();
    test_proto();
    test_pc_wrap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
